// File: rtl/harvard_data_ram.sv
// Data-side memory responder for the Harvard CPU: combinational reads, single-edge writes,
// a post-reset zeroing sequencer, a sticky access-error flag and saturating access counters.
module harvard_data_ram #(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_1000,
   parameter int unsigned DEPTH_WORDS    = 256,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [31:0] data_address,
   input  logic        data_write,
   input  logic        data_read,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic        ready,
   output logic        access_error,
   output logic [15:0] read_count,
   output logic [15:0] write_count
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clear_idx_q, clear_idx_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;
   logic [15:0]   rd_cnt_q, rd_cnt_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   offset;
   logic [AW-1:0] index;
   logic          in_range, aligned, conflict, valid;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   // Range check works on the base-relative offset so the upper bound never overflows 32 bits.
   always_comb begin
      offset   = data_address - ADDR_BASE;
      in_range = (data_address >= ADDR_BASE) && ({1'b0, offset} < SPAN);
      aligned  = (data_address[1:0] == 2'b00);
      index    = offset[AW+1:2];
      conflict = data_read && data_write;
      valid    = ready_q && in_range && aligned && !conflict;
   end

   always_comb begin
      state_d     = state_q;
      clear_idx_d = clear_idx_q;
      err_d       = err_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      mem_we      = 1'b0;
      mem_waddr   = index;
      mem_wdata   = data_writedata;

      case (state_q)
         ST_CLEAR: begin
            mem_we      = 1'b1;
            mem_waddr   = clear_idx_q;
            mem_wdata   = '0;
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            mem_we = data_write && valid && clk_enable;
         end
         default: state_d = ST_READY;
      endcase

      if (clk_enable) begin
         if (data_read && valid && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
         if (data_write && valid && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
         if ((data_read || data_write) && (!ready_q || !in_range || !aligned || conflict)) begin
            err_d = 1'b1;
         end
      end

      // The reset edge itself must leave the array untouched.
      if (reset) begin
         mem_we = 1'b0;
      end

      ready_d = (state_d == ST_READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clear_idx_q <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         clear_idx_q <= clear_idx_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign data_readdata = (data_read && valid) ? mem[index] : '0;
   assign ready         = ready_q;
   assign access_error  = err_q;
   assign read_count    = rd_cnt_q;
   assign write_count   = wr_cnt_q;

endmodule

// File: tb/tb_harvard_data_ram.sv
// Directed bench for harvard_data_ram: clear timing, read/write, boundaries, errors,
// clock-enable gating, reset mid-clear and counter saturation.
module tb_harvard_data_ram;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;
   logic        ready;
   logic        access_error;
   logic [15:0] read_count;
   logic [15:0] write_count;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned n;

   harvard_data_ram #(
      .ADDR_BASE      (32'h0000_1000),
      .DEPTH_WORDS    (256),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clk_enable     (clk_enable),
      .data_address   (data_address),
      .data_write     (data_write),
      .data_read      (data_read),
      .data_writedata (data_writedata),
      .data_readdata  (data_readdata),
      .ready          (ready),
      .access_error   (access_error),
      .read_count     (read_count),
      .write_count    (write_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      data_read      = 1'b0;
      data_write     = 1'b0;
      data_address   = 32'h0000_1000;
      data_writedata = '0;
   endtask

   // Pulses reset for one edge and counts cycles until ready (bounded).
   task automatic reset_and_clear(output int unsigned cycles);
      idle();
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      cycles = 0;
      while (!ready && cycles < 400) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      clk_enable = 1'b1;
      idle();

      // Reset state
      tick();
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_err", {31'b0, access_error}, 32'h0);
      check("rst_rdcnt", {16'b0, read_count}, 32'h0);
      check("rst_wrcnt", {16'b0, write_count}, 32'h0);

      // Clear timing, with a gated read of 0x1000 during the clear
      reset        = 1'b0;
      clk_enable   = 1'b0;
      data_read    = 1'b1;
      data_address = 32'h0000_1000;
      #1;
      check("clear_rd_during", data_readdata, 32'h0);
      n = 0;
      while (!ready && n < 400) begin
         tick();
         n++;
      end
      check("clear_cycles", n, 32'd256);
      check("clear_err_gated", {31'b0, access_error}, 32'h0);
      clk_enable = 1'b1;
      #1;
      check("clear_rd_after", data_readdata, 32'h0);
      idle();

      // Write then read
      data_write     = 1'b1;
      data_address   = 32'h0000_1004;
      data_writedata = 32'hDEAD_BEEF;
      #1;
      check("wr_same_cycle_rd", data_readdata, 32'h0);
      tick();
      data_write = 1'b0;
      data_read  = 1'b1;
      #1;
      check("rd_after_wr", data_readdata, 32'hDEAD_BEEF);
      tick();
      check("wr_cnt_1", {16'b0, write_count}, 32'd1);
      check("rd_cnt_1", {16'b0, read_count}, 32'd1);
      check("no_err_yet", {31'b0, access_error}, 32'h0);

      // Upper boundary word
      idle();
      data_write     = 1'b1;
      data_address   = 32'h0000_13FC;
      data_writedata = 32'hA5A5_0001;
      tick();
      data_write = 1'b0;
      data_read  = 1'b1;
      #1;
      check("rd_top_word", data_readdata, 32'hA5A5_0001);
      idle();

      // Out-of-range writes above and below the window
      data_write     = 1'b1;
      data_address   = 32'h0000_1400;
      data_writedata = 32'h1111_1111;
      #1;
      check("err_before_edge", {31'b0, access_error}, 32'h0);
      tick();
      check("err_above", {31'b0, access_error}, 32'h1);
      data_address   = 32'h0000_0FFC;
      data_writedata = 32'h2222_2222;
      tick();
      data_write   = 1'b0;
      data_read    = 1'b1;
      data_address = 32'h0000_1400;
      #1;
      check("rd_above_zero", data_readdata, 32'h0);
      data_address = 32'h0000_1000;
      #1;
      check("word0_untouched", data_readdata, 32'h0);
      data_address = 32'h0000_13FC;
      #1;
      check("top_untouched", data_readdata, 32'hA5A5_0001);
      data_read = 1'b0;
      #1;
      check("wr_cnt_2", {16'b0, write_count}, 32'd2);

      // Misaligned read
      reset_and_clear(n);
      check("clear2_cycles", n, 32'd256);
      data_read    = 1'b1;
      data_address = 32'h0000_1002;
      #1;
      check("misaligned_rd", data_readdata, 32'h0);
      tick();
      check("misaligned_err", {31'b0, access_error}, 32'h1);
      check("misaligned_rdcnt", {16'b0, read_count}, 32'd0);

      // Conflicting read+write
      reset_and_clear(n);
      data_read      = 1'b1;
      data_write     = 1'b1;
      data_address   = 32'h0000_1008;
      data_writedata = 32'hFFFF_FFFF;
      #1;
      check("conflict_rd", data_readdata, 32'h0);
      tick();
      check("conflict_err", {31'b0, access_error}, 32'h1);
      check("conflict_wrcnt", {16'b0, write_count}, 32'd0);
      data_write = 1'b0;
      #1;
      check("conflict_nowrite", data_readdata, 32'h0);

      // clk_enable = 0 freezes writes, counters and error capture
      reset_and_clear(n);
      clk_enable     = 1'b0;
      data_write     = 1'b1;
      data_address   = 32'h0000_1010;
      data_writedata = 32'h1234_5678;
      tick();
      data_address = 32'h0000_2000;
      tick();
      check("gated_wrcnt", {16'b0, write_count}, 32'd0);
      check("gated_err", {31'b0, access_error}, 32'h0);
      clk_enable   = 1'b1;
      data_write   = 1'b0;
      data_read    = 1'b1;
      data_address = 32'h0000_1010;
      #1;
      check("gated_mem", data_readdata, 32'h0);
      check("gated_rdcnt", {16'b0, read_count}, 32'd0);

      // Reset in the middle of the clear sequence
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      check("midclear_not_ready", {31'b0, ready}, 32'h0);
      reset_and_clear(n);
      check("midclear_cycles", n, 32'd256);

      // Read counter saturation
      data_read    = 1'b1;
      data_address = 32'h0000_1000;
      for (int i = 0; i < 65540; i++) begin
         tick();
         if (i == 65533) check("rdcnt_fffe", {16'b0, read_count}, 32'h0000_FFFE);
      end
      check("rdcnt_sat", {16'b0, read_count}, 32'h0000_FFFF);
      check("sat_wrcnt", {16'b0, write_count}, 32'd0);
      check("sat_err", {31'b0, access_error}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
